// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA sync generator: scan phases,
// the 640x480@60 default mode and the coordinate width.
package vga_timing_pkg;

  // Coordinates are 10 bits wide, so neither axis may exceed 1024 positions.
  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  // Segment of a scan line (or of a frame, for the vertical axis).
  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_e;

  // 640x480@60 timing with a 25 MHz pixel clock derived from 50 MHz.
  localparam int DEF_PIX_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  // Number of positions along one axis.
  function automatic int axis_total(input int act_len, input int fp_len,
                                    input int sync_len, input int bp_len);
    return act_len + fp_len + sync_len + bp_len;
  endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One scan axis: a position counter that walks ACT -> FP -> SYNC -> BP and
// wraps, producing the matching sync level. Used once for x and once for y.
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FP_LEN     = DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BP_LEN     = DEF_H_BP,
  parameter bit SYNC_POL   = DEF_SYNC_POL
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  output logic [COORD_W-1:0] count_o,
  output phase_e             phase_o,
  output logic               wrap_o,
  output logic               sync_o
);

  localparam int TOTAL = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);

  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] FP_START   = COORD_W'(ACTIVE_LEN);
  localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE_LEN + FP_LEN);
  localparam logic [COORD_W-1:0] BP_START   = COORD_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

  logic [COORD_W-1:0] count_q, count_d;
  phase_e             phase_q, phase_d;
  logic               sync_q, sync_d;
  logic               at_last;

  assign at_last = (count_q == LAST);
  assign wrap_o  = en_i && at_last;
  assign count_o = count_q;
  assign phase_o = phase_q;
  assign sync_o  = sync_q;

  // Next position, phase and sync level; later segments are tested first so
  // a zero-length segment is skipped rather than entered.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    sync_d  = sync_q;
    if (en_i) begin
      if (at_last) begin
        count_d = '0;
        phase_d = ACT;
      end else begin
        count_d = count_q + 1'b1;
        if (count_d == BP_START) begin
          phase_d = BP;
        end else if (count_d == SYNC_START) begin
          phase_d = SYNC;
        end else if (count_d == FP_START) begin
          phase_d = FP;
        end
      end
      sync_d = (phase_d == SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Reset parks the axis on its last position so the first advance lands on 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= LAST;
      phase_q <= BP;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: divides the system clock down to the pixel rate and
// drives scan position, syncs, activevideo and frame_start for drawing blocks.
// Everything changes on the px_clk falling edge and is sampled on its rise.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst,
  output logic               px_clk,
  output logic               px_en,
  output logic [COORD_W-1:0] x_px,
  output logic [COORD_W-1:0] y_px,
  output logic               activevideo,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = $clog2(PIX_DIV);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF   = DIV_W'(PIX_DIV / 2);
  localparam logic [COORD_W-1:0] H_LAST_ACT = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LAST_ACT = COORD_W'(V_ACTIVE - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds the 10-bit coordinate range");
  end

  if (PIX_DIV < 2 || (PIX_DIV % 2) != 0) begin : g_div_check
    $error("vga_sync_gen: PIX_DIV must be even and at least 2");
  end

  logic [DIV_W-1:0]   div_q, div_d;
  logic               px_clk_q, px_en_q, active_q, frame_start_q;
  logic               advance;
  logic               v_en;
  logic               h_wrap, v_wrap;
  logic               h_sync, v_sync;
  logic               h_act_next, v_act_next;
  logic [COORD_W-1:0] h_count, v_count;
  phase_e             h_phase, v_phase;

  // The position moves on the clk edge where the divider wraps back to 0.
  assign advance = (div_q == DIV_LAST);
  assign v_en    = advance && h_wrap;

  vga_axis_ctr #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (advance),
    .count_o (h_count),
    .phase_o (h_phase),
    .wrap_o  (h_wrap),
    .sync_o  (h_sync)
  );

  vga_axis_ctr #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (v_en),
    .count_o (v_count),
    .phase_o (v_phase),
    .wrap_o  (v_wrap),
    .sync_o  (v_sync)
  );

  // Divider step plus whether the next position on each axis is still visible.
  always_comb begin
    div_d      = advance ? '0 : div_q + 1'b1;
    h_act_next = h_wrap || ((h_phase == ACT) && (h_count != H_LAST_ACT));
    v_act_next = v_wrap || ((v_phase == ACT) && !(v_en && (v_count == V_LAST_ACT)));
  end

  // Pixel clock, advance strobe and position-derived flags, all registered so
  // they change together with x_px/y_px.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      px_clk_q      <= 1'b0;
      px_en_q       <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      px_clk_q <= (div_d >= DIV_HALF);
      px_en_q  <= advance;
      if (advance) begin
        active_q      <= h_act_next && v_act_next;
        frame_start_q <= h_wrap && v_wrap;
      end
    end
  end

  assign px_clk      = px_clk_q;
  assign px_en       = px_en_q;
  assign x_px        = h_count;
  assign y_px        = v_count;
  assign activevideo = active_q;
  assign hsync       = h_sync;
  assign vsync       = v_sync;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: the default 640x480 instance covers reset,
// divider, line timing and mid-line reset; a shrunken PIX_DIV=4, active-high
// instance covers whole-frame behaviour in a short run.
module tb_vga_sync_gen;

  logic       clock;
  logic       resetA, resetB;

  logic       pxClkA, pxEnA, activeA, hsyncA, vsyncA, frameStartA;
  logic [9:0] xA, yA;
  logic       pxClkB, pxEnB, activeB, hsyncB, vsyncB, frameStartB;
  logic [9:0] xB, yB;

  int checks = 0;
  int errors = 0;

  vga_sync_gen dutA (
    .clk         (clock),
    .rst         (resetA),
    .px_clk      (pxClkA),
    .px_en       (pxEnA),
    .x_px        (xA),
    .y_px        (yA),
    .activevideo (activeA),
    .hsync       (hsyncA),
    .vsync       (vsyncA),
    .frame_start (frameStartA)
  );

  // Small mode: 15 pixels x 11 lines, 4 clk per pixel, syncs active-high.
  vga_sync_gen #(
    .PIX_DIV  (4),
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (6),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (2),
    .SYNC_POL (1'b1)
  ) dutB (
    .clk         (clock),
    .rst         (resetB),
    .px_clk      (pxClkB),
    .px_en       (pxEnB),
    .x_px        (xB),
    .y_px        (yB),
    .activevideo (activeB),
    .hsync       (hsyncB),
    .vsync       (vsyncB),
    .frame_start (frameStartB)
  );

  // 10 ns system clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive both resets, then advance by a number of falling clock edges.
  task automatic applyStimulus(input logic rstA, input logic rstB, input int negedges);
    resetA = rstA;
    resetB = rstB;
    repeat (negedges) @(negedge clock);
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Directed sequence.
  initial begin
    int expX, expY, budget, posErr, actCnt1, lateAct;
    int lowCnt[2], lowFirst[2], lowLast[2];
    int bx, by, prevX, prevY, cyc, starts, posErrB;
    int startTime[2];
    int actCntB, vHighCnt, vMin, vMax, hHighCnt, hMin, hMax;
    int pxClkHigh, pxEnCnt, fsPulses, wrapPrevX, wrapPrevY, wrapX, wrapY;
    logic [15:0] activeLines;

    // ---------------- reset state ----------------
    $display("[TB] reset held");
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("reset x_px", xA, 799);
    checkOutput("reset y_px", yA, 524);
    checkOutput("reset activevideo", activeA, 0);
    checkOutput("reset hsync", hsyncA, 1);
    checkOutput("reset vsync", vsyncA, 1);
    checkOutput("reset px_clk", pxClkA, 0);
    checkOutput("reset px_en", pxEnA, 0);
    checkOutput("reset frame_start", frameStartA, 0);

    // ---------------- release and first pixel ----------------
    $display("[TB] reset released on default instance");
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("rel1 px_clk", pxClkA, 1);
    checkOutput("rel1 px_en", pxEnA, 0);
    checkOutput("rel1 x_px", xA, 799);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("first px_en", pxEnA, 1);
    checkOutput("first x_px", xA, 0);
    checkOutput("first y_px", yA, 0);
    checkOutput("first activevideo", activeA, 1);
    checkOutput("first frame_start", frameStartA, 1);
    checkOutput("first hsync", hsyncA, 1);

    // ---------------- divider, PIX_DIV=2 ----------------
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("div px_clk", pxClkA, i % 2);
      checkOutput("div px_en", pxEnA, (i % 2) == 0);
      checkOutput("div x_px", xA, i / 2);
    end

    // ---------------- two scan lines of horizontal timing ----------------
    $display("[TB] scanning lines 0 and 1");
    expX = 4;
    expY = 0;
    budget = 0;
    posErr = 0;
    actCnt1 = 0;
    lateAct = 0;
    for (int l = 0; l < 2; l++) begin
      lowCnt[l] = 0;
      lowFirst[l] = -1;
      lowLast[l] = -1;
    end
    while (expY != 2 && budget < 4000) begin
      applyStimulus(1'b0, 1'b1, 1);
      budget++;
      if (pxEnA === 1'b1) begin
        if (expX == 799) begin
          expX = 0;
          expY++;
        end else begin
          expX++;
        end
        if (xA !== 10'(expX) || yA !== 10'(expY)) posErr++;
        if (expY < 2 && hsyncA === 1'b0) begin
          lowCnt[expY]++;
          if (lowFirst[expY] < 0) lowFirst[expY] = expX;
          lowLast[expY] = expX;
        end
        if (expY == 1 && activeA === 1'b1) actCnt1++;
        if (expX >= 640 && activeA !== 1'b0) lateAct++;
      end
    end
    checkOutput("scan reached x_px", xA, 0);
    checkOutput("scan reached y_px", yA, 2);
    checkOutput("scan position errors", posErr, 0);
    for (int l = 0; l < 2; l++) begin
      checkOutput("hsync low count", lowCnt[l], 96);
      checkOutput("hsync low first x", lowFirst[l], 656);
      checkOutput("hsync low last x", lowLast[l], 751);
    end
    checkOutput("line1 active pixels", actCnt1, 640);
    checkOutput("active beyond x 639", lateAct, 0);

    // ---------------- asynchronous reset mid-line ----------------
    $display("[TB] mid-line reset");
    budget = 0;
    while (!(pxEnA === 1'b1 && xA === 10'd300) && budget < 1000) begin
      applyStimulus(1'b0, 1'b1, 1);
      budget++;
    end
    checkOutput("midline x_px before reset", xA, 300);
    checkOutput("midline y_px before reset", yA, 2);
    checkOutput("midline active before reset", activeA, 1);
    #2 resetA = 1'b1;
    #1;
    checkOutput("async x_px", xA, 799);
    checkOutput("async y_px", yA, 524);
    checkOutput("async activevideo", activeA, 0);
    checkOutput("async hsync", hsyncA, 1);
    checkOutput("async px_en", pxEnA, 0);
    checkOutput("async px_clk", pxClkA, 0);
    @(negedge clock);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("restart px_en", pxEnA, 1);
    checkOutput("restart x_px", xA, 0);
    checkOutput("restart y_px", yA, 0);
    checkOutput("restart frame_start", frameStartA, 1);

    // ---------------- small mode, full frame ----------------
    $display("[TB] small-mode frame on second instance");
    bx = 14;
    by = 10;
    cyc = 0;
    starts = 0;
    posErrB = 0;
    startTime[0] = -1;
    startTime[1] = -1;
    actCntB = 0;
    activeLines = '0;
    vHighCnt = 0;
    vMin = 99;
    vMax = -1;
    hHighCnt = 0;
    hMin = 99;
    hMax = -1;
    pxClkHigh = 0;
    pxEnCnt = 0;
    fsPulses = 0;
    wrapPrevX = -1;
    wrapPrevY = -1;
    wrapX = -1;
    wrapY = -1;
    applyStimulus(1'b0, 1'b0, 0);
    while (starts < 2 && cyc < 3000) begin
      applyStimulus(1'b0, 1'b0, 1);
      cyc++;
      if (pxEnB === 1'b1) begin
        prevX = bx;
        prevY = by;
        if (bx == 14) begin
          bx = 0;
          by = (by == 10) ? 0 : by + 1;
        end else begin
          bx++;
        end
        if (xB !== 10'(bx) || yB !== 10'(by)) posErrB++;
        if (frameStartB === 1'b1) begin
          starts++;
          if (starts <= 2) startTime[starts-1] = cyc;
          if (starts == 2) begin
            wrapPrevX = prevX;
            wrapPrevY = prevY;
            wrapX = int'(xB);
            wrapY = int'(yB);
          end
        end
        if (starts == 1) begin
          if (frameStartB === 1'b1) fsPulses++;
          if (activeB === 1'b1) begin
            actCntB++;
            activeLines[by] = 1'b1;
          end
          if (vsyncB === 1'b1) begin
            vHighCnt++;
            if (by < vMin) vMin = by;
            if (by > vMax) vMax = by;
          end
          if (hsyncB === 1'b1) begin
            hHighCnt++;
            if (bx < hMin) hMin = bx;
            if (bx > hMax) hMax = bx;
          end
        end
      end
      if (starts == 1) begin
        if (pxClkB === 1'b1) pxClkHigh++;
        if (pxEnB === 1'b1) pxEnCnt++;
      end
    end
    checkOutput("B frame starts seen", starts, 2);
    checkOutput("B first frame_start cycle", startTime[0], 4);
    checkOutput("B frame period clk", startTime[1] - startTime[0], 660);
    checkOutput("B position errors", posErrB, 0);
    checkOutput("B frame_start pulses", fsPulses, 1);
    checkOutput("B active pixels", actCntB, 48);
    checkOutput("B active lines", $countones(activeLines), 6);
    checkOutput("B vsync high pixels", vHighCnt, 30);
    checkOutput("B vsync first line", vMin, 7);
    checkOutput("B vsync last line", vMax, 8);
    checkOutput("B hsync high pixels", hHighCnt, 33);
    checkOutput("B hsync first x", hMin, 10);
    checkOutput("B hsync last x", hMax, 12);
    checkOutput("B px_clk high clk", pxClkHigh, 330);
    checkOutput("B px_en strobes", pxEnCnt, 165);
    checkOutput("B wrap from x", wrapPrevX, 14);
    checkOutput("B wrap from y", wrapPrevY, 10);
    checkOutput("B wrap to x", wrapX, 0);
    checkOutput("B wrap to y", wrapY, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
